// File: rtl/fetch_unit.sv
// RV32I instruction fetch: holds the PC, fetches from instruction memory and
// hands one instruction at a time to decode; applies redirects, halts on ECALL.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        halt,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALTED} state_t;

  state_t state;

  // Redirect targets are word aligned; sequential fetch wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic taken,
                                          input logic [31:0] target);
    next_pc = taken ? (target & 32'hFFFFFFFC) : (cur + 32'd4);
  endfunction

  assign imem_addr = pc;
  assign opcode    = instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      halt        <= 1'b0;
      instret     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (imem_valid) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            if (instr == HALT_INSTR) begin
              instr <= NOP_INSTR;
              halt  <= 1'b1;
              state <= HALTED;
            end else begin
              pc       <= next_pc(pc, branch_taken, branch_target);
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        HALTED: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halt        <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a scripted memory pushes expected
// {pc, instr} pairs, decode-side acceptance pops and compares them.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ECALL = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_valid = 1'b0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        halt;
  logic [31:0] instret;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .opcode(opcode), .pc(pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_opcode", {25'd0, opcode}, 32'h13);
    check("rst_vld", {31'd0, instr_valid}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_instret", instret, 32'd0);
    rst_n   = 1'b1;
    exp_pc  = 32'h0;
    exp_ret = 32'd0;
    sb.delete();
  endtask

  // Answer the next request after 'waits' wait cycles; branch inputs are
  // wiggled during the wait to show they are ignored outside acceptance.
  task automatic serve(input int waits, input logic [31:0] word);
    int t = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      branch_taken  = 1'b1;
      branch_target = 32'hDEADBEEF;
      @(negedge clk);
      check("req_hold", {31'd0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, exp_pc);
      check("vld_wait", {31'd0, instr_valid}, 32'd0);
    end
    branch_taken = 1'b0;
    imem_valid   = 1'b1;
    imem_rdata   = word;
    sb.push_back('{exp_pc, word});
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    check("vld_rise", {31'd0, instr_valid}, 32'd1);
    check("opcode", {25'd0, opcode}, {25'd0, word[6:0]});
    check("req_drop", {31'd0, imem_req}, 32'd0);
  endtask

  // Stall 'stall' cycles with ready low, then accept with the given redirect.
  task automatic accept(input int stall, input logic bt, input logic [31:0] tgt);
    exp_t e;
    check("sb_avail", sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int i = 0; i < stall; i++) begin
      instr_ready   = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h0BADF00C;
      @(negedge clk);
      check("stall_vld", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, e.instr);
      check("stall_pc", pc, e.pc);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_instret", instret, exp_ret);
    end
    check("acc_vld", {31'd0, instr_valid}, 32'd1);
    check("acc_instr", instr, e.instr);
    check("acc_pc", pc, e.pc);
    instr_ready   = 1'b1;
    branch_taken  = bt;
    branch_target = tgt;
    @(negedge clk);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    exp_ret = exp_ret + 32'd1;
    check("instret", instret, exp_ret);
    check("post_vld", {31'd0, instr_valid}, 32'd0);
    if (e.instr == ECALL) begin
      check("halt_set", {31'd0, halt}, 32'd1);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_pc", pc, e.pc);
      check("halt_instr", instr, NOP);
      exp_pc = e.pc;
    end else begin
      exp_pc = bt ? {tgt[31:2], 2'b00} : e.pc + 32'd4;
      check("next_req", {31'd0, imem_req}, 32'd1);
      check("next_addr", imem_addr, exp_pc);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // zero-wait stream at 0,4,8
    serve(0, 32'h00100093); accept(0, 1'b0, 32'd0);
    serve(0, 32'h00200113); accept(0, 1'b0, 32'd0);
    serve(0, 32'h00300193); accept(0, 1'b0, 32'd0);
    check("instret_3", instret, 32'd3);
    serve(0, 32'h00400213); accept(0, 1'b0, 32'd0);

    // 3 wait cycles at 0x10, then a 5-cycle decode stall
    serve(3, 32'h000120B7);
    accept(5, 1'b0, 32'd0);

    // redirect to 0x103 -> 0x100, then a waited fetch with branch noise
    serve(0, 32'h00500293); accept(0, 1'b1, 32'h00000103);
    serve(2, 32'h00600313); accept(0, 1'b0, 32'd0);
    check("ignored_branch_pc", exp_pc, 32'h00000104);
    serve(0, 32'h0000006F); accept(1, 1'b1, 32'h00000020);

    // ECALL at 0x20 halts
    serve(0, ECALL);
    accept(0, 1'b0, 32'd0);
    imem_valid = 1'b1; imem_rdata = 32'h00700393;
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halted_halt", {31'd0, halt}, 32'd1);
      check("halted_vld", {31'd0, instr_valid}, 32'd0);
      check("halted_req", {31'd0, imem_req}, 32'd0);
      check("halted_pc", pc, 32'h00000020);
      check("halted_instret", instret, exp_ret);
    end
    imem_valid = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    do_reset();

    // reset while a response is pending in REQ
    begin
      int t = 0;
      while (!imem_req && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    imem_valid = 1'b1; imem_rdata = 32'h00A00093;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("async_vld", {31'd0, instr_valid}, 32'd0);
    check("async_instr", instr, NOP);
    @(negedge clk);
    imem_valid = 1'b0; imem_rdata = 32'd0;
    rst_n   = 1'b1;
    exp_pc  = 32'h0;
    exp_ret = 32'd0;
    serve(0, 32'h00B00093);
    accept(0, 1'b1, 32'hFFFFFFFF);
    serve(1, 32'h00C00093);
    accept(0, 1'b0, 32'd0);
    check("wrap_pc", exp_pc, 32'h0);
    serve(0, 32'h00D00093);
    accept(0, 1'b0, 32'd0);
    check("final_instret", instret, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
